// File: rtl/clk_rate_pkg.sv
// Shared types and the decade half-period table for the run-time selectable clock divider.
package clk_rate_pkg;

  localparam int NUM_RATES = 8;
  localparam int SEL_W     = 3;

  // Half-period in fabric cycles: 50 MHz, 1 MHz, ... 10 Hz, 1 Hz from a 100 MHz source
  localparam int unsigned HALF_TAB [NUM_RATES] = '{
    32'd1, 32'd50, 32'd500, 32'd5_000,
    32'd50_000, 32'd500_000, 32'd5_000_000, 32'd50_000_000
  };

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RUN      = 2'd1,
    ST_PENDING  = 2'd2
  } state_e;

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter with terminal-count compare; toggles the output clock at each boundary.
module clk_div_core #(
  parameter int CTR_W = 26
) (
  input  logic             clk_sys,
  input  logic             restart,
  input  logic             run,
  input  logic [CTR_W-1:0] half_m1,
  output logic             clk,
  output logic             rise,
  output logic             fall_next
);

  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             term;

  assign term      = (ctr_q == half_m1);
  assign fall_next = run && term && clk_q;

  always_comb begin
    ctr_d  = '0;
    clk_d  = 1'b0;
    rise_d = 1'b0;
    if (run) begin
      if (term) begin
        clk_d  = ~clk_q;
        rise_d = ~clk_q;
      end else begin
        ctr_d = ctr_q + CTR_W'(1);
        clk_d = clk_q;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (restart) begin
      ctr_q  <= '0;
      clk_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      ctr_q  <= ctr_d;
      clk_q  <= clk_d;
      rise_q <= rise_d;
    end
  end

  assign clk  = clk_q;
  assign rise = rise_q;

endmodule

// File: rtl/clk_rate_controller.sv
// Rate-select FSM and request handshake; new rates are applied only at a falling boundary.
//   state       | meaning
//   ST_DISABLED | output held low, requests applied on the next cycle
//   ST_RUN      | dividing at cur_sel, ready for a request
//   ST_PENDING  | dividing at old rate, pend_sel waits for the falling boundary
module clk_rate_controller
  import clk_rate_pkg::*;
#(
  parameter int RESET_SEL = 7,
  parameter int CTR_W     = 26
) (
  input  logic             incoming_CLK100MHZ,
  input  logic             reset,
  input  logic             enable,
  input  logic             sel_valid,
  input  logic [SEL_W-1:0] sel,
  output logic             sel_ready,
  output logic             sel_done,
  output logic [SEL_W-1:0] cur_sel,
  output logic             outgoing_CLK,
  output logic             tick
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
  logic             sel_done_q, sel_done_d;
  logic             accept, run;
  logic             div_clk, div_rise, fall_next;
  logic [CTR_W-1:0] half_m1;

  assign accept  = sel_valid && sel_ready;
  assign half_m1 = CTR_W'(HALF_TAB[cur_sel_q] - 32'd1);
  // Hold the counter for the apply cycle so the new rate starts from a clean low phase
  assign run     = enable && !(state_q == ST_DISABLED && accept);

  always_ff @(posedge incoming_CLK100MHZ) begin
    if (reset) begin
      state_q    <= ST_DISABLED;
      cur_sel_q  <= SEL_W'(RESET_SEL);
      pend_sel_q <= '0;
      sel_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_sel_q  <= cur_sel_d;
      pend_sel_q <= pend_sel_d;
      sel_done_q <= sel_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_sel_d  = cur_sel_q;
    pend_sel_d = pend_sel_q;
    sel_done_d = 1'b0;
    case (state_q)
      ST_DISABLED: begin
        if (accept) begin
          cur_sel_d  = sel;
          sel_done_d = 1'b1;
        end
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_DISABLED;
          if (accept) begin
            cur_sel_d  = sel;
            sel_done_d = 1'b1;
          end
        end else if (accept) begin
          pend_sel_d = sel;
          state_d    = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (!enable || fall_next) begin
          cur_sel_d  = pend_sel_q;
          sel_done_d = 1'b1;
          state_d    = enable ? ST_RUN : ST_DISABLED;
        end
      end
      default: state_d = ST_DISABLED;
    endcase
  end

  always_comb begin
    sel_ready    = (state_q != ST_PENDING) && !sel_done_q;
    sel_done     = sel_done_q;
    cur_sel      = cur_sel_q;
    outgoing_CLK = div_clk;
    tick         = div_rise;
  end

  clk_div_core #(
    .CTR_W(CTR_W)
  ) u_div (
    .clk_sys  (incoming_CLK100MHZ),
    .restart  (reset),
    .run      (run),
    .half_m1  (half_m1),
    .clk      (div_clk),
    .rise     (div_rise),
    .fall_next(fall_next)
  );

endmodule

// File: tb/tb_clk_rate_controller.sv
// Directed bench for clk_rate_controller: vector table plus hand-written multi-cycle sequences.
module tb_clk_rate_controller;

  logic       clk = 1'b0;
  logic       reset, enable, sel_valid;
  logic [2:0] sel;
  logic       sel_ready, sel_done, outgoing_CLK, tick;
  logic [2:0] cur_sel;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clk_rate_controller #(.RESET_SEL(7), .CTR_W(26)) dut (
    .incoming_CLK100MHZ(clk),
    .reset             (reset),
    .enable            (enable),
    .sel_valid         (sel_valid),
    .sel               (sel),
    .sel_ready         (sel_ready),
    .sel_done          (sel_done),
    .cur_sel           (cur_sel),
    .outgoing_CLK      (outgoing_CLK),
    .tick              (tick)
  );

  typedef struct {
    logic       rst, en, vld;
    logic [2:0] s;
    logic       e_clk, e_tick, e_done, e_rdy;
    logic [2:0] e_cur;
  } vec_t;

  vec_t vecs [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Count consecutive cycles with outgoing_CLK at lvl, bounded by limit
  task automatic measure_level(input logic lvl, input int limit, output int n);
    n = 0;
    while (outgoing_CLK == lvl && n < limit) begin
      n++;
      step();
    end
  endtask

  // From the acceptance cycle, step until sel_done; lat is cycles from acceptance
  task automatic wait_done(input logic keep_valid, input int limit, output int lat, output int rdy_low);
    lat = 0;
    rdy_low = 0;
    do begin
      step();
      lat++;
      if (!keep_valid) sel_valid = 1'b0;
      if (!sel_ready) rdy_low++;
    end while (!sel_done && lat < limit);
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat, rl, cnt_done, cnt_hi;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};

    reset = 1'b1; enable = 1'b0; sel_valid = 1'b0; sel = 3'd0;
    step();

    for (int i = 0; i < 9; i++) begin
      reset = vecs[i].rst; enable = vecs[i].en; sel_valid = vecs[i].vld; sel = vecs[i].s;
      step();
      chk($sformatf("v%0d_clk", i),  int'(outgoing_CLK), int'(vecs[i].e_clk));
      chk($sformatf("v%0d_tick", i), int'(tick),         int'(vecs[i].e_tick));
      chk($sformatf("v%0d_done", i), int'(sel_done),     int'(vecs[i].e_done));
      chk($sformatf("v%0d_rdy", i),  int'(sel_ready),    int'(vecs[i].e_rdy));
      chk($sformatf("v%0d_cur", i),  int'(cur_sel),      int'(vecs[i].e_cur));
    end
    sel_valid = 1'b0;

    // Enable rising with cur_sel=1: 50 low cycles, then rise with tick
    enable = 1'b1;
    measure_level(1'b0, 200, n);
    chk("en_rise_low", n, 50);
    chk("en_rise_tick", int'(tick), 1);
    step();
    chk("tick_one_cycle", int'(tick), 0);
    repeat (9) step();

    // Request sel=2 at high-phase cycle 10
    chk("rdy_before_req", int'(sel_ready), 1);
    sel_valid = 1'b1; sel = 3'd2;
    wait_done(1'b0, 200, lat, rl);
    chk("hi_req_latency", lat, 40);
    chk("hi_req_rdy_low", rl, 40);
    chk("hi_req_clk_low", int'(outgoing_CLK), 0);
    chk("hi_req_cur", int'(cur_sel), 2);
    measure_level(1'b0, 2000, n);
    chk("rate2_low", n, 500);
    measure_level(1'b1, 2000, n);
    chk("rate2_high", n, 500);

    // Hold sel_valid with sel=3: first accept in low phase at ctr=0, second after sel_done
    sel_valid = 1'b1; sel = 3'd3;
    wait_done(1'b1, 3000, lat, rl);
    chk("lo_req_latency", lat, 1000);
    chk("lo_req_cur", int'(cur_sel), 3);
    chk("rdy_low_at_done", int'(sel_ready), 0);
    step();
    chk("rdy_after_done", int'(sel_ready), 1);
    chk("done_one_cycle", int'(sel_done), 0);
    wait_done(1'b0, 20000, lat, rl);
    chk("held_req_latency", lat, 9999);
    chk("held_req_cur", int'(cur_sel), 3);

    // Disable from RUN, then select rate 2 while disabled
    step();
    enable = 1'b0;
    step();
    chk("dis_clk", int'(outgoing_CLK), 0);
    chk("dis_done", int'(sel_done), 0);
    chk("dis_rdy", int'(sel_ready), 1);
    sel_valid = 1'b1; sel = 3'd2;
    step();
    sel_valid = 1'b0;
    chk("dis_apply_done", int'(sel_done), 1);
    chk("dis_apply_cur", int'(cur_sel), 2);
    enable = 1'b1;
    measure_level(1'b0, 2000, n);
    chk("rate2_en_low", n, 500);
    repeat (10) step();
    sel_valid = 1'b1; sel = 3'd1;
    step();
    sel_valid = 1'b0;
    chk("pend_rdy", int'(sel_ready), 0);
    repeat (5) step();
    enable = 1'b0;
    step();
    chk("drop_en_clk", int'(outgoing_CLK), 0);
    chk("drop_en_done", int'(sel_done), 1);
    chk("drop_en_cur", int'(cur_sel), 1);
    chk("drop_en_tick", int'(tick), 0);
    step();
    chk("drop_en_rdy", int'(sel_ready), 1);
    chk("drop_en_done2", int'(sel_done), 0);
    measure_level(1'b0, 30, n);
    chk("dis_hold_low", n, 30);

    // Reset while PENDING drops the request
    enable = 1'b1;
    measure_level(1'b0, 200, n);
    chk("rate1_low", n, 50);
    repeat (5) step();
    sel_valid = 1'b1; sel = 3'd0;
    step();
    sel_valid = 1'b0;
    chk("rst_pend_rdy", int'(sel_ready), 0);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_clk", int'(outgoing_CLK), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_done", int'(sel_done), 0);
    chk("rst_rdy", int'(sel_ready), 1);
    chk("rst_cur", int'(cur_sel), 7);
    cnt_done = 0; cnt_hi = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (sel_done) cnt_done++;
      if (outgoing_CLK) cnt_hi++;
    end
    chk("rst_no_done", cnt_done, 0);
    chk("rst_no_clk", cnt_hi, 0);
    chk("rst_cur_kept", int'(cur_sel), 7);
    enable = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
